// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the responder's channel FSM states.
// Both the master and the RAM responder use these response constants.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } t_wr_state;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } t_rd_state;

  function automatic logic resp_is_okay(input logic [1:0] resp);
    return resp == RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_ram.sv
// Word RAM with one synchronous read port and one byte-strobed write port.
// Reads return the contents from before a same-edge write (read-before-write).
module axi4_lite_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi4_lite_ram_slave.sv
// AXI4-Lite responder in front of a byte-strobed word RAM. Read and write channels
// run independent FSMs; out-of-range accesses get DECERR, misaligned ones SLVERR.
module axi4_lite_ram_slave #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        AW_VALID,
  output logic                        AW_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
  input  logic [2:0]                  AW_PROT,
  input  logic                        W_VALID,
  output logic                        W_READY,
  input  logic [AXI_DATA_WIDTH-1:0]   W_DATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
  output logic                        B_VALID,
  input  logic                        B_READY,
  output logic [1:0]                  B_RESP,
  input  logic                        AR_VALID,
  output logic                        AR_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
  input  logic [2:0]                  AR_PROT,
  output logic                        R_VALID,
  input  logic                        R_READY,
  output logic [AXI_DATA_WIDTH-1:0]   R_DATA,
  output logic [1:0]                  R_RESP
);

  import axi4_lite_pkg::*;

  localparam int BYTES    = AXI_DATA_WIDTH / 8;
  localparam int BYTE_LSB = $clog2(BYTES);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(MEM_DEPTH * BYTES);

  typedef struct packed {
    logic [1:0]       resp;
    logic [IDX_W-1:0] idx;
  } t_decode;

  // The extra top bit of the subtraction is the borrow, i.e. addr < BASE_ADDR.
  function automatic t_decode decode(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH:0] diff;
    t_decode                 d;
    diff  = {1'b0, addr} - {1'b0, BASE_ADDR};
    d.idx = diff[BYTE_LSB +: IDX_W];
    if (diff[AXI_ADDR_WIDTH] || (diff[AXI_ADDR_WIDTH-1:0] >= MEM_BYTES)) begin
      d.resp = RESP_DECERR;
    end else if (diff[BYTE_LSB-1:0] != '0) begin
      d.resp = RESP_SLVERR;
    end else begin
      d.resp = RESP_OKAY;
    end
    return d;
  endfunction

  logic unused_prot;
  assign unused_prot = ^{AW_PROT, AR_PROT};

  t_wr_state                   wr_state;
  t_wr_state                   wr_next;
  logic                        aw_full;
  logic                        w_full;
  logic                        aw_take;
  logic                        w_take;
  logic                        wr_commit;
  logic                        b_done;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_p0;
  logic [AXI_DATA_WIDTH-1:0]   w_data_p0;
  logic [BYTES-1:0]            w_strb_p0;
  logic [1:0]                  b_resp_p1;
  t_decode                     wr_dec;

  t_rd_state                   rd_state;
  t_rd_state                   rd_next;
  logic                        ar_take;
  logic [1:0]                  r_resp_p1;
  logic                        r_okay_p1;
  t_decode                     rd_dec;
  logic [AXI_DATA_WIDTH-1:0]   ram_rd_data;

  assign wr_dec = decode(aw_addr_p0);
  assign rd_dec = decode(AR_ADDR);

  // Write channel: capture AW and W independently, commit once both are held.
  always_comb begin
    wr_next   = wr_state;
    aw_take   = 1'b0;
    w_take    = 1'b0;
    wr_commit = 1'b0;
    b_done    = 1'b0;
    AW_READY  = 1'b0;
    W_READY   = 1'b0;
    B_VALID   = 1'b0;
    unique case (wr_state)
      W_IDLE: begin
        AW_READY = !aw_full;
        W_READY  = !w_full;
        aw_take  = AW_VALID && !aw_full;
        w_take   = W_VALID && !w_full;
        if (aw_full && w_full) begin
          wr_commit = 1'b1;
          wr_next   = W_RESP;
        end
      end
      W_RESP: begin
        B_VALID = 1'b1;
        if (B_READY) begin
          b_done  = 1'b1;
          wr_next = W_IDLE;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      wr_state  <= W_IDLE;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      b_resp_p1 <= RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      if (aw_take) begin
        aw_full <= 1'b1;
      end else if (b_done) begin
        aw_full <= 1'b0;
      end
      if (w_take) begin
        w_full <= 1'b1;
      end else if (b_done) begin
        w_full <= 1'b0;
      end
      if (wr_commit) begin
        b_resp_p1 <= wr_dec.resp;
      end
    end
  end

  // Holding registers carry data only; their validity lives in aw_full/w_full.
  always_ff @(posedge clk) begin
    if (aw_take) begin
      aw_addr_p0 <= AW_ADDR;
    end
    if (w_take) begin
      w_data_p0 <= W_DATA;
      w_strb_p0 <= W_STRB;
    end
  end

  assign B_RESP = b_resp_p1;

  // Read channel: one beat per AR, data held until accepted.
  always_comb begin
    rd_next  = rd_state;
    ar_take  = 1'b0;
    AR_READY = 1'b0;
    R_VALID  = 1'b0;
    unique case (rd_state)
      R_IDLE: begin
        AR_READY = 1'b1;
        if (AR_VALID) begin
          ar_take = 1'b1;
          rd_next = axi4_lite_pkg::R_DATA;
        end
      end
      axi4_lite_pkg::R_DATA: begin
        R_VALID = 1'b1;
        if (R_READY) begin
          rd_next = R_IDLE;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      rd_state  <= R_IDLE;
      r_resp_p1 <= RESP_OKAY;
      r_okay_p1 <= 1'b0;
    end else begin
      rd_state <= rd_next;
      if (ar_take) begin
        r_resp_p1 <= rd_dec.resp;
        r_okay_p1 <= resp_is_okay(rd_dec.resp);
      end
    end
  end

  assign R_RESP = r_resp_p1;
  // RAM output is not reset, so error beats and the reset state are forced to zero here.
  assign R_DATA = r_okay_p1 ? ram_rd_data : '0;

  axi4_lite_ram #(
    .DATA_W (AXI_DATA_WIDTH),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rd_en   (ar_take),
    .rd_idx  (rd_dec.idx),
    .rd_data (ram_rd_data),
    .wr_en   (wr_commit && resp_is_okay(wr_dec.resp)),
    .wr_idx  (wr_dec.idx),
    .wr_data (w_data_p0),
    .wr_strb (w_strb_p0)
  );

endmodule

// File: doc/axi4_lite_ram_slave.md
# axi4_lite_ram_slave

AXI4-Lite responder that terminates read and write transactions from `axi4_lite_master` into an internal byte-strobed word RAM. It is the memory-side endpoint for cache traffic in simulation and small on-chip memories. It answers out-of-range accesses with DECERR and misaligned accesses with SLVERR. Read and write channels run independently, sharing only the storage.

## Interface
- `AXI_ADDR_WIDTH`, 64: AXI address width.
- `AXI_DATA_WIDTH`, 32: data width; must be 32 or 64.
- `MEM_DEPTH`, 1024: number of data words; must be a power of two.
- `BASE_ADDR`, 0: byte address of word 0.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `arst` in 1: reset, synchronous and active-low.
- `AW_VALID` in 1, `AW_READY` out 1, `AW_ADDR` in AXI_ADDR_WIDTH, `AW_PROT` in 3: write address channel.
- `W_VALID` in 1, `W_READY` out 1, `W_DATA` in AXI_DATA_WIDTH, `W_STRB` in AXI_DATA_WIDTH/8: write data channel.
- `B_VALID` out 1, `B_READY` in 1, `B_RESP` out 2: write response channel.
- `AR_VALID` in 1, `AR_READY` out 1, `AR_ADDR` in AXI_ADDR_WIDTH, `AR_PROT` in 3: read address channel.
- `R_VALID` out 1, `R_READY` in 1, `R_DATA` out AXI_DATA_WIDTH, `R_RESP` out 2: read data channel.

## Operation
- Address decode:
  - offset = addr − BASE_ADDR, computed modulo 2^AXI_ADDR_WIDTH.
  - addr < BASE_ADDR, or offset ≥ MEM_DEPTH·(AXI_DATA_WIDTH/8), gives DECERR (2'b11).
  - Otherwise, nonzero low log2(AXI_DATA_WIDTH/8) bits give SLVERR (2'b10).
  - Otherwise OKAY (2'b00), with index = offset >> log2(bytes).
  - `*_PROT` is ignored.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, AW and W are captured independently into holding registers `aw_full` and `w_full`.
  - `AW_READY` = W_IDLE & !aw_full. `W_READY` = W_IDLE & !w_full.
  - AW and W may arrive in either order or in the same cycle.
  - Once both are full, at the next edge:
    - if the response is OKAY, bytes with `W_STRB[i]`=1 are written;
    - `B_RESP` is registered, `B_VALID` goes to 1, and the FSM moves to W_RESP.
  - On error, memory is untouched.
  - In W_RESP, `B_VALID`/`B_RESP` hold until `B_READY`. At that edge both holding registers clear and the FSM returns to W_IDLE.
  - `W_STRB` = 0 with OKAY: no byte changes, response is OKAY.
- Read FSM states: R_IDLE, R_DATA.
  - `AR_READY` = R_IDLE.
  - On the AR handshake edge, `R_DATA` <= mem[index] (0 on error), `R_RESP` is registered, `R_VALID` goes to 1, and the FSM moves to R_DATA.
  - `R_VALID`, `R_DATA` and `R_RESP` hold until `R_READY`, then the FSM returns to R_IDLE.
- Read/write collision: a read sampled at the same edge as a write commit to the same word returns the old data.
- Memory contents are not reset; they are X until written.

## Timing
- Reset (`arst`=0 at an edge):
  - both FSMs go to IDLE and holding registers clear;
  - `AW_READY`, `W_READY` and `AR_READY` read 1 after the edge;
  - `B_VALID`, `R_VALID`, `B_RESP`, `R_RESP` and `R_DATA` are 0;
  - an in-flight transaction is dropped without a response.
- Write:
  - last of AW/W handshakes at edge N; memory updated and `B_VALID`=1 after edge N+1;
  - with `B_READY` held at 1, the response completes at edge N+2, and `AW_READY`/`W_READY` are 1 again after it.
- Read:
  - AR handshake at edge N; `R_VALID`=1 after edge N;
  - with `R_READY`=1, the beat completes at edge N+1; `AR_READY`=1 after it.
- Throughput:
  - one read per 2 cycles;
  - one write per 3 cycles when AW and W arrive together.
- Outputs are registered, or driven combinationally from FSM state only. There is no path from VALID/READY inputs to any output in the same cycle.
- Holding a VALID/READY low stalls indefinitely with no state loss.

## Structure
- The shared package `axi4_lite_pkg` holds:
  - response constants `RESP_OKAY`, `RESP_SLVERR`, `RESP_DECERR`;
  - enums `t_wr_state` and `t_rd_state`.
  - `axi4_lite_master` uses the same response constants.
- Sub-module `axi4_lite_ram`: 1 synchronous read port, 1 byte-strobed write port, MEM_DEPTH×AXI_DATA_WIDTH, read-before-write.
- Decode is a function in this module, shared by both channels.

## Test plan
- Write then read:
  - stimulus: write 0xDEADBEEF to BASE_ADDR+0x10, STRB 4'hF, then read the same address;
  - required: `B_RESP`=0 one cycle after the write commit; `R_DATA`=0xDEADBEEF, `R_RESP`=0, `R_VALID` one cycle after AR.
- Strobed write:
  - stimulus: word holds 0xDEADBEEF; write 0x11223344 with STRB 4'b0101, then read;
  - required: 0xDE22BE44.
- Channel order and backpressure:
  - stimulus: W presented 3 cycles before AW; `B_READY` held 0 for 4 cycles;
  - required: `B_VALID` stays 1 with a stable `B_RESP`; `AW_READY`/`W_READY` stay 0 until the B handshake.
- Error responses:
  - read at BASE_ADDR + MEM_DEPTH·4 → `R_RESP`=2'b11, `R_DATA`=0;
  - write to BASE_ADDR+0x2 → `B_RESP`=2'b10 and memory unchanged.
- Collision:
  - stimulus: word holds 0xAAAAAAAA; AR sampled on the write-commit edge of 0x55555555 to the same word;
  - required: the read returns 0xAAAAAAAA and a follow-up read returns 0x55555555.
- Reset mid-transaction:
  - stimulus: `arst`=0 while in W_RESP and R_DATA;
  - required: all VALIDs are 0 and all READYs are 1 after the edge, and no stale response appears afterwards.
